// File: rtl/b8_pkg.sv
// Shared definitions for the front-end fetch path: default widths,
// the canonical NOP encoding and the address/instruction pair type.
package b8_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_INST_W = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_INST_W-1:0] inst;
    } inst_pair;

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: register array with one synchronous write
// port, one asynchronous read port and synchronous clear on reset.
module inst_queue_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO of
// {instAddr, inst} pairs with valid/ready handshakes and one-cycle flush.
module inst_queue
    import b8_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned INST_W = DEF_INST_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       jumpFlag_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [ADDR_W-1:0]          instAddr_i,
    input  logic [INST_W-1:0]          inst_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [ADDR_W-1:0]          instAddr_o,
    output logic [INST_W-1:0]          inst_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]            wptr;
    logic [PW-1:0]            rptr;
    logic [CW-1:0]            count;
    logic                     push;
    logic                     pop;
    logic [ADDR_W+INST_W-1:0] wdata;
    logic [ADDR_W+INST_W-1:0] rdata;

    // Handshakes depend only on registered count and the flush request.
    assign ready_o = (count < CW'(DEPTH)) & ~jumpFlag_i;
    assign valid_o = (count != '0) & ~jumpFlag_i;
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;
    assign count_o = count;

    always_ff @(posedge clk) begin
        if (reset || jumpFlag_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign wdata = {instAddr_i, inst_i};
    assign {instAddr_o, inst_o} = rdata;

    inst_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        jumpFlag_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] instAddr_i;
    logic [31:0] inst_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instAddr_o;
    logic [31:0] inst_o;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;

    logic [63:0] mq[$];

    always #5 clk = ~clk;

    inst_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .INST_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .jumpFlag_i (jumpFlag_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .instAddr_i (instAddr_i),
        .inst_i     (inst_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .instAddr_o (instAddr_o),
        .inst_o     (inst_o),
        .count_o    (count_o)
    );

    // Apply inputs for one cycle, advance the model by the spec rules, settle after the edge.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] ins,
                         input logic r, input logic j);
        bit push, pop;
        valid_i = v; instAddr_i = a; inst_i = ins; ready_i = r; jumpFlag_i = j;
        push = v && (mq.size() < DEPTH) && !j;
        pop  = r && (mq.size() > 0) && !j;
        @(posedge clk);
        if (reset || j) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({a, ins});
        end
        #1;
    endtask

    task automatic set_idle();
        valid_i = 0; ready_i = 0; jumpFlag_i = 0; instAddr_i = '0; inst_i = '0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        drive(0, '0, '0, 0, 0);
        drive(0, '0, '0, 0, 0);
        reset = 0;
        set_idle();
    endtask

    task automatic test_reset();
        reset = 1;
        drive(1, 32'hDEAD, 32'hBEEF, 1, 0);
        drive(1, 32'hDEAD, 32'hBEEF, 1, 0);
        valid_i = 0; #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (instAddr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", instAddr_o); end
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
        reset = 0;
        set_idle();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", ready_o); end
    endtask

    task automatic test_fill();
        do_reset();
        drive(1, 32'h0, 32'h11, 0, 0);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b exp=1", valid_o); end
        drive(1, 32'h4, 32'h22, 0, 0);
        drive(1, 32'h8, 32'h33, 0, 0);
        set_idle();
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL fill_count got=%0d exp=3", count_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL fill_valid got=%b exp=1", valid_o); end
        checks++; if (instAddr_o !== 32'h0 || inst_o !== 32'h11) begin
            errors++; $display("FAIL fill_head got=%h/%h exp=0/11", instAddr_o, inst_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready got=%b exp=1", ready_o); end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'(4 * k), 32'(k + 1), 0, 0);
        end
        set_idle();
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", ready_o); end
        checks++; if (count_o !== 3'd4 || mq.size() != 4) begin
            errors++; $display("FAIL full_count got=%0d exp=4", count_o); end
        ready_i = 1; #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_ready got=%b exp=0", ready_o); end
        drive(0, '0, '0, 1, 0);
        set_idle();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL after_pop_ready got=%b exp=1", ready_o); end
        checks++; if (instAddr_o !== 32'h4) begin errors++; $display("FAIL after_pop_head got=%h exp=4", instAddr_o); end
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL after_pop_count got=%0d exp=3", count_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr;
        do_reset();
        drive(1, 32'h100, 32'h1000, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            valid_i = (k < 16); instAddr_i = 32'h100 + 32'(4 * k); inst_i = 32'h1000 + 32'(k);
            ready_i = 1; #1;
            exp_addr = 32'h100 + 32'(4 * (k - 1));
            checks++; if (valid_o !== 1'b1 || instAddr_o !== exp_addr || inst_o !== 32'h1000 + 32'(k - 1)) begin
                errors++; $display("FAIL stream_head[%0d] got=%b/%h/%h exp=1/%h", k, valid_o, instAddr_o, inst_o, exp_addr); end
            checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count_o); end
            drive(valid_i, instAddr_i, inst_i, 1, 0);
        end
        set_idle();
        checks++; if (count_o !== 3'd0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL stream_drain got=%0d/%b exp=0/0", count_o, valid_o); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 3; k++) drive(1, 32'(16 * k), 32'(k), 0, 0);
        valid_i = 1; instAddr_i = 32'h200; inst_i = 32'h77; jumpFlag_i = 1; ready_i = 1; #1;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++; $display("FAIL flush_mask got=v%b/r%b exp=0/0", valid_o, ready_o); end
        drive(1, 32'h200, 32'h77, 1, 1);
        set_idle();
        checks++; if (count_o !== 3'd0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_count got=%0d/%b exp=0/0", count_o, valid_o); end
        drive(1, 32'h300, 32'h88, 0, 0);
        set_idle();
        checks++; if (instAddr_o !== 32'h300 || count_o !== 3'd1) begin
            errors++; $display("FAIL flush_refill got=%h/%0d exp=300/1", instAddr_o, count_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 32'h40, 32'h55, 0, 0);
        drive(1, 32'h44, 32'h66, 0, 0);
        reset = 1;
        drive(1, 32'h48, 32'h77, 1, 1);
        jumpFlag_i = 0; valid_i = 0; #1;
        checks++; if (count_o !== 3'd0 || valid_o !== 1'b0 || instAddr_o !== 32'h0 || inst_o !== 32'h0) begin
            errors++; $display("FAIL mid_reset got=%0d/%b/%h/%h exp=0/0/0/0", count_o, valid_o, instAddr_o, inst_o); end
        reset = 0;
        set_idle();
    endtask

    task automatic test_random();
        logic v, r, j;
        logic [31:0] a, ins;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v = 1'($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 2) != 0);
            j = 1'($urandom_range(0, 15) == 0);
            a = $urandom; ins = $urandom;
            valid_i = v; ready_i = r; jumpFlag_i = j; instAddr_i = a; inst_i = ins; #1;
            checks++; if (count_o !== 3'(mq.size())) begin
                errors++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, count_o, mq.size()); end
            checks++; if (valid_o !== (mq.size() > 0 && !j) || ready_o !== (mq.size() < DEPTH && !j)) begin
                errors++; $display("FAIL rand_hs[%0d] got=v%b/r%b qsize=%0d jump=%b", n, valid_o, ready_o, mq.size(), j); end
            if (mq.size() > 0) begin
                checks++; if ({instAddr_o, inst_o} !== mq[0]) begin
                    errors++; $display("FAIL rand_head[%0d] got=%h%h exp=%h", n, instAddr_o, inst_o, mq[0]); end
            end
            drive(v, a, ins, r, j);
        end
        set_idle();
    endtask

    initial begin
        reset = 1; valid_i = 0; ready_i = 0; jumpFlag_i = 0; instAddr_i = '0; inst_i = '0;
        test_reset();
        test_fill();
        test_full();
        test_stream();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
